awmc_actuator_driver: RTL
=========================

// Module: awmc_actuator_driver
// PURPOSE
// - Consumer side of the AWMC controller's stage/done interface: decodes stage codes into registered actuator commands.
// - Drives water valve, drain pump, motor (enable/direction/fast), door lock and buzzer; monitors stage sequencing and latches fault.
// - Sits between AWMC and the physical I/O drivers; one instance per machine.
// PARAMETERS
// - DIR_PERIOD   default 8   cycles per motor_dir half-period in WASH/RINSE (>=1)
// - DOOR_DELAY   default 4   cycles door_lock stays asserted after cycle completion (>=1)
// - BUZZ_CYCLES  default 6   buzzer pulse length on completion (>=1)
// - RAMP_CYCLES  default 5   SPIN cycles before motor_fast (used only with AWMC_SPIN_RAMP_EN)
// PORTS
// - clk         in   1  system clock, all logic on rising edge
// - reset       in   1  synchronous, active-high reset
// - stage       in   3  controller stage code (0 FILL,1 WASH,2 RINSE,3 DRAIN,4 SPIN,7 IDLE/PAUSED)
// - done        in   1  controller completion flag (level)
// - water_valve out  1  open inlet valve
// - drain_pump  out  1  run drain pump
// - motor_en    out  1  drum motor on
// - motor_dir   out  1  drum direction (0 fwd, 1 rev)
// - motor_fast  out  1  high-speed spin
// - door_lock   out  1  door locked
// - buzzer      out  1  completion buzzer
// - fault       out  1  sticky sequence fault
// BEHAVIOUR
// - Reset (sync): all outputs 0, FSM=IDLE, last_stage=7, counters 0. Reset mid-operation drops every actuator on the next edge.
// - All outputs registered; response to stage/done change appears 1 cycle later.
// - FSM states: IDLE, RUN, PAUSED, UNLOCK_WAIT, FAULT.
//   IDLE: stage==0 -> RUN; stage 1..6 -> FAULT; stage 7 stays.
//   RUN: stage==last_stage or last_stage+1 (<=4) -> RUN; stage==7 & done -> UNLOCK_WAIT; stage==7 & !done -> PAUSED; else -> FAULT.
//   PAUSED: stage==7 stays; stage==last_stage -> RUN; any other code -> FAULT.
//   UNLOCK_WAIT: count DOOR_DELAY cycles then IDLE; stage==0 during wait -> RUN (new cycle, counter cleared).
//   FAULT: sticky until reset; all actuators 0 except door_lock=1 and drain_pump=1; fault=1.
// - last_stage updated with stage whenever stage in 0..4 while in IDLE/RUN/PAUSED.
// - Codes 5,6 are illegal in every state -> FAULT. Transition 4->7 without done in same cycle -> PAUSED (done may arrive later only via restart).
// - Decode in RUN: FILL valve=1; WASH/RINSE motor_en=1, motor_dir toggles every DIR_PERIOD cycles (counter restarts at 0, dir=0 on stage entry);
//   DRAIN pump=1; SPIN pump=1, motor_en=1, motor_dir=0, motor_fast=1.
// - PAUSED: all actuators 0, door_lock=1, dir counter frozen and restored on resume.
// - door_lock=1 in RUN, PAUSED, UNLOCK_WAIT, FAULT; 0 in IDLE.
// - buzzer: BUZZ_CYCLES-cycle pulse on rising edge of done while in RUN; retrigger during pulse restarts count; independent of later FSM transitions except reset/FAULT (cleared).
// - Simultaneous stage==7 & done rising: treated as completion (UNLOCK_WAIT + buzzer), not pause.
// CONFIGURATION
// - AWMC_SPIN_RAMP_EN defined: on SPIN entry motor_fast=0 for first RAMP_CYCLES cycles, then 1; pause/resume restarts ramp.
// - AWMC_SPIN_RAMP_EN undefined: motor_fast=1 from first SPIN output cycle; RAMP_CYCLES unused.
// STRUCTURE
// - awmc_pkg: stage code localparams (ST_FILL..ST_SPIN, ST_IDLE=3'd7), FSM state enum/localparams.
// - Sub-module awmc_pulse_timer (load, width param, busy out): instanced for buzzer pulse and door-unlock delay.
// - Direction toggle and spin ramp counters live in top level.
// TESTING
// - Full cycle 7,0,1,2,3,4,7+done, 4 cycles/stage -> valve,motor,motor,pump,pump+fast in order; door_lock 1 until DOOR_DELAY=4 cycles after done; buzzer high 6 cycles.
// - WASH held 20 cycles, DIR_PERIOD=8 -> motor_dir 0 for 8, 1 for 8, 0 thereafter; dir=0 again on RINSE entry.
// - Pause in RINSE (2->7, done=0) for 5 cycles, resume 2 -> actuators 0, door_lock 1 while paused; motor resumes with frozen dir phase; no fault.
// - Illegal: resume 7->3 after pause in 2, or stage=5 any time -> fault=1 next cycle, pump=1, lock=1, motor/valve 0; persists until reset.
// - Reset asserted mid-SPIN -> all outputs 0 next edge; subsequent stage 0 starts clean RUN.
// - With AWMC_SPIN_RAMP_EN, RAMP_CYCLES=5: SPIN entry -> motor_fast 0 for 5 cycles then 1; without macro, 1 immediately.

Source files
------------

// File: rtl/awmc_pkg.sv
// Shared stage codes, FSM states and actuator bundle for the AWMC actuator driver.
package awmc_pkg;

  localparam logic [2:0] ST_FILL  = 3'd0;
  localparam logic [2:0] ST_WASH  = 3'd1;
  localparam logic [2:0] ST_RINSE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_SPIN  = 3'd4;
  localparam logic [2:0] ST_IDLE  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_RUN         = 3'd1,
    S_PAUSED      = 3'd2,
    S_UNLOCK_WAIT = 3'd3,
    S_FAULT       = 3'd4
  } state_e;

  typedef struct packed {
    logic valve;
    logic pump;
    logic motor_en;
    logic motor_dir;
    logic motor_fast;
    logic door_lock;
    logic fault;
  } act_t;

  // Codes 5 and 6 are never issued by a healthy controller.
  function automatic logic stage_illegal(input logic [2:0] s);
    return (s == 3'd5) || (s == 3'd6);
  endfunction

endpackage

// File: rtl/awmc_pulse_timer.sv
// Retriggerable pulse timer: busy_o is high for WIDTH cycles after a load, clr_i aborts.
module awmc_pulse_timer #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic load_i,
  output logic busy_o
);

  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/awmc_actuator_driver.sv
// Decodes AWMC stage/done into registered actuator commands and latches sequence faults.
// Optional feature macro: AWMC_SPIN_RAMP_EN (delays motor_fast by RAMP_CYCLES on SPIN entry).
module awmc_actuator_driver
  import awmc_pkg::*;
#(
  parameter int DIR_PERIOD  = 8,
  parameter int DOOR_DELAY  = 4,
  parameter int BUZZ_CYCLES = 6,
  parameter int RAMP_CYCLES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] stage,
  input  logic       done,
  output logic       water_valve,
  output logic       drain_pump,
  output logic       motor_en,
  output logic       motor_dir,
  output logic       motor_fast,
  output logic       door_lock,
  output logic       buzzer,
  output logic       fault
);

`ifdef AWMC_SPIN_RAMP_EN
  localparam bit RampEn = 1'b1;
`else
  localparam bit RampEn = 1'b0;
`endif
  localparam int DW = (DIR_PERIOD < 2) ? 1 : $clog2(DIR_PERIOD);
  localparam int RW = (RAMP_CYCLES < 2) ? 1 : $clog2(RAMP_CYCLES + 1);

  state_e        state_q, state_d;
  logic [2:0]    last_q, last_d;
  logic          done_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          dph_q, dph_d;
  logic [RW-1:0] ramp_q, ramp_d;
  act_t          act_q, act_d;
  logic          door_busy, door_clr, door_load;
  logic          buzz_busy, buzz_clr, buzz_load;
  logic          run_d, washing, new_stage;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (stage == ST_FILL)      state_d = S_RUN;
        else if (stage != ST_IDLE) state_d = S_FAULT;
      end
      S_RUN: begin
        if ((stage == last_q) ||
            (({1'b0, stage} == ({1'b0, last_q} + 4'd1)) && (stage <= ST_SPIN)))
          state_d = S_RUN;
        else if (stage == ST_IDLE)
          state_d = done ? S_UNLOCK_WAIT : S_PAUSED;
        else
          state_d = S_FAULT;
      end
      S_PAUSED: begin
        if (stage == ST_IDLE)     state_d = S_PAUSED;
        else if (stage == last_q) state_d = S_RUN;
        else                      state_d = S_FAULT;
      end
      S_UNLOCK_WAIT: begin
        if (stage == ST_FILL) state_d = S_RUN;
        else if (!door_busy)  state_d = S_IDLE;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
    if (stage_illegal(stage)) state_d = S_FAULT;
  end

  // A restart from the unlock wait begins a fresh sequence at FILL.
  always_comb begin
    last_d = last_q;
    if (((state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_PAUSED)) && (stage <= ST_SPIN))
      last_d = stage;
    else if ((state_q == S_UNLOCK_WAIT) && (stage == ST_FILL))
      last_d = stage;
  end

  assign run_d     = (state_d == S_RUN);
  assign washing   = (stage == ST_WASH) || (stage == ST_RINSE);
  assign new_stage = (stage != last_q);

  // Direction phase only advances on RUN cycles, so a pause freezes it.
  always_comb begin
    dcnt_d = dcnt_q;
    dph_d  = dph_q;
    if (run_d && washing) begin
      if (new_stage) begin
        dcnt_d = '0;
        dph_d  = 1'b0;
      end else if (dcnt_q == DW'(DIR_PERIOD - 1)) begin
        dcnt_d = '0;
        dph_d  = ~dph_q;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  always_comb begin
    ramp_d = ramp_q;
    if (run_d && (stage == ST_SPIN)) begin
      if (new_stage || (state_q == S_PAUSED)) ramp_d = '0;
      else if (ramp_q < RW'(RAMP_CYCLES))     ramp_d = ramp_q + RW'(1);
    end
  end

  always_comb begin
    act_d = '0;
    case (state_d)
      S_RUN: begin
        act_d.door_lock = 1'b1;
        case (stage)
          ST_FILL:  act_d.valve = 1'b1;
          ST_WASH,
          ST_RINSE: begin
            act_d.motor_en  = 1'b1;
            act_d.motor_dir = dph_d;
          end
          ST_DRAIN: act_d.pump = 1'b1;
          ST_SPIN: begin
            act_d.pump       = 1'b1;
            act_d.motor_en   = 1'b1;
            act_d.motor_fast = !RampEn || (ramp_d >= RW'(RAMP_CYCLES));
          end
          default: ;
        endcase
      end
      S_PAUSED, S_UNLOCK_WAIT: act_d.door_lock = 1'b1;
      S_FAULT: begin
        act_d.door_lock = 1'b1;
        act_d.pump      = 1'b1;
        act_d.fault     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= ST_IDLE;
      done_q  <= 1'b0;
      dcnt_q  <= '0;
      dph_q   <= 1'b0;
      ramp_q  <= '0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      done_q  <= done;
      dcnt_q  <= dcnt_d;
      dph_q   <= dph_d;
      ramp_q  <= ramp_d;
      act_q   <= act_d;
    end
  end

  assign door_clr  = (state_d != S_UNLOCK_WAIT);
  assign door_load = (state_q != S_UNLOCK_WAIT);
  assign buzz_load = (state_q == S_RUN) && done && !done_q;
  assign buzz_clr  = (state_d == S_FAULT);

  // The entry cycle counts as one wait cycle, hence the shortened width.
  awmc_pulse_timer #(.WIDTH(DOOR_DELAY - 1)) u_door_timer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (door_clr),
    .load_i (door_load),
    .busy_o (door_busy)
  );

  awmc_pulse_timer #(.WIDTH(BUZZ_CYCLES)) u_buzz_timer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (buzz_clr),
    .load_i (buzz_load),
    .busy_o (buzz_busy)
  );

  assign water_valve = act_q.valve;
  assign drain_pump  = act_q.pump;
  assign motor_en    = act_q.motor_en;
  assign motor_dir   = act_q.motor_dir;
  assign motor_fast  = act_q.motor_fast;
  assign door_lock   = act_q.door_lock;
  assign fault       = act_q.fault;
  assign buzzer      = buzz_busy;

endmodule
